sel_decoder: RTL and testbench
==============================

SEL_DECODER -- requirements
Module: sel_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 4, width of the selection code.
REQ-002 SHALL have parameter NUM_OUT, default 16, number of one-hot outputs; legal range 2..2**SEL_W.
REQ-003 SHALL have parameter PULSE_CYCLES, default 8, cycles an output is driven per accepted selection; minimum 1.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 4, all-zero gap after each drive; minimum 1.
REQ-005 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  block enable; low blocks acceptance and aborts an active drive.
REQ-008 SHALL have port in_valid  input  1  selection offered.
REQ-009 SHALL have port in_sel  input  SEL_W  selection code.
REQ-010 SHALL have port in_ready  output  1  block can accept a selection.
REQ-011 SHALL have port out  output  NUM_OUT  registered one-hot drive.
REQ-012 SHALL have port busy  output  1  high in DRIVE or HOLDOFF.
REQ-013 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-014 SHALL have port abort  output  1  one-cycle pulse when a drive is cut short by enable low.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a rejected out-of-range selection.

Function
REQ-016 SHALL implement a state machine with states IDLE, DRIVE and HOLDOFF.
REQ-017 SHALL drive in_ready = enable AND (state == IDLE), combinationally.
REQ-018 SHALL accept a selection when in_valid and in_ready are both high at a clock edge.
REQ-019 SHALL, on accepting a legal selection, latch in_sel, enter DRIVE, and set out = 1 << in_sel from the next cycle (latency 1).
REQ-020 SHALL hold out stable for exactly PULSE_CYCLES cycles in DRIVE, independent of later in_sel or in_valid changes.
REQ-021 SHALL then enter HOLDOFF with out = 0 for exactly HOLDOFF_CYCLES cycles, and then return to IDLE.
REQ-022 SHALL pulse done in the last HOLDOFF cycle of a normal (non-aborted) sequence.
REQ-023 SHALL, if enable is low at an edge in DRIVE, clear out, pulse abort and enter HOLDOFF on that edge; done SHALL NOT pulse for that sequence.
REQ-024 SHALL complete HOLDOFF even if enable is low; it SHALL return to IDLE and stay there until enable is high.
REQ-025 SHALL size the cycle counter to $clog2(max(PULSE_CYCLES, HOLDOFF_CYCLES)+1) bits, with no wrap inside a phase.
REQ-026 SHALL never drive more than one bit of out high in any cycle.

Reset
REQ-027 SHALL, on reset assertion, immediately (asynchronously) force state IDLE, out = 0, busy = 0, done = 0, abort = 0, err = 0, counter = 0 and latched selection = 0.
REQ-028 SHALL, on reset mid-DRIVE, clear out without a HOLDOFF phase; the first acceptance SHALL be possible on the first edge after reset deasserts.

Configuration
REQ-029 SHALL honour macro SEL_DECODER_RANGE_CHECK_EN.
REQ-030 SHALL, with SEL_DECODER_RANGE_CHECK_EN defined, treat an accepted in_sel >= NUM_OUT as consumed: err pulses next cycle, state stays IDLE, out stays 0.
REQ-031 SHALL, without the macro, tie err to 0; an out-of-range in_sel then runs a normal DRIVE/HOLDOFF sequence with out = 0 and done pulsing.

Structure
REQ-032 SHALL place the state enum type (sel_state_t) and the default parameter constants in the shared package sel_decoder_pkg.
REQ-033 SHALL use one sub-module, onehot_dec, as a parametrised combinational SEL_W-to-NUM_OUT decoder that the FSM registers.

Verification
REQ-034 SHALL test: defaults, enable=1, in_sel=5 valid for 1 cycle -> out=16'h0020 for cycles 1..8, 0 for cycles 9..12, done pulse at cycle 12, in_ready high at cycle 13.
REQ-035 SHALL test: in_valid held high with in_sel changing 3->9 during DRIVE -> out stays 16'h0008 and the second selection is accepted only after done.
REQ-036 SHALL test: enable dropped in DRIVE cycle 3 -> out=0 and abort pulse at the next edge, 4 HOLDOFF cycles, no done.
REQ-037 SHALL test: NUM_OUT=10, macro defined, in_sel=12 -> err pulse, out=0, busy=0; the same stimulus without the macro -> err=0, out=0, done after 12 cycles.
REQ-038 SHALL test: reset asserted mid-DRIVE between clock edges -> out=0 at once; after release, in_sel=0 -> out=16'h0001 one cycle later.
REQ-039 SHALL check, by assertion on every cycle, that out is one-hot or zero, and that out is nonzero only in DRIVE.

Source files
------------

// File: rtl/sel_decoder_pkg.sv
// Shared state type and default parameters for the sel_decoder block.
package sel_decoder_pkg;

    localparam int DEF_SEL_W          = 4;
    localparam int DEF_NUM_OUT        = 16;
    localparam int DEF_PULSE_CYCLES   = 8;
    localparam int DEF_HOLDOFF_CYCLES = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_HOLDOFF = 2'd2
    } sel_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sel_decoder_onehot_dec.sv
// Combinational SEL_W-to-NUM_OUT one-hot decoder; codes >= NUM_OUT decode to all-zero.
module onehot_dec
    import sel_decoder_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int NUM_OUT = DEF_NUM_OUT
) (
    input  logic [SEL_W-1:0]   sel_i,
    output logic [NUM_OUT-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            dec_o[i] = (sel_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/sel_decoder.sv
// Pulsed one-hot selection driver: IDLE -> DRIVE (PULSE_CYCLES) -> HOLDOFF (HOLDOFF_CYCLES).
// Optional macro SEL_DECODER_RANGE_CHECK_EN rejects out-of-range codes with an err pulse.
module sel_decoder
    import sel_decoder_pkg::*;
#(
    parameter int SEL_W          = DEF_SEL_W,
    parameter int NUM_OUT        = DEF_NUM_OUT,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out,
    output logic               busy,
    output logic               done,
    output logic               abort,
    output logic               err
);

    localparam int               CNT_W      = $clog2(max_int(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    sel_state_t         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   dec_sel;
    logic [NUM_OUT-1:0] out_q;
    logic [NUM_OUT-1:0] dec_out;
    logic               done_q;
    logic               abort_q;
    logic               aborted_q;
    logic               err_q;
    logic               accept;

    // Decode the live code while idle, the latched code once a drive is running.
    assign dec_sel = (state_q == S_IDLE) ? in_sel : sel_q;

    onehot_dec #(
        .SEL_W  (SEL_W),
        .NUM_OUT(NUM_OUT)
    ) u_dec (
        .sel_i(dec_sel),
        .dec_o(dec_out)
    );

    assign in_ready = enable && (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

`ifdef SEL_DECODER_RANGE_CHECK_EN
    logic sel_legal;
    assign sel_legal = |dec_out;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
`ifdef SEL_DECODER_RANGE_CHECK_EN
                        if (!sel_legal) err_q <= 1'b1;
                        else
`endif
                        begin
                            state_q   <= S_DRIVE;
                            cnt_q     <= PULSE_LAST;
                            sel_q     <= in_sel;
                            out_q     <= dec_out;
                            aborted_q <= 1'b0;
                        end
                    end
                end
                S_DRIVE: begin
                    if (!enable) begin
                        abort_q   <= 1'b1;
                        aborted_q <= 1'b1;
                        out_q     <= '0;
                        state_q   <= S_HOLDOFF;
                        cnt_q     <= HOLD_LAST;
                    end else if (cnt_q == '0) begin
                        out_q   <= '0;
                        state_q <= S_HOLDOFF;
                        cnt_q   <= HOLD_LAST;
                        // A single-cycle holdoff is its own last cycle.
                        done_q  <= (HOLDOFF_CYCLES == 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        out_q <= dec_out;
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q == '0) state_q <= S_IDLE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                    done_q <= (cnt_q == CNT_W'(1)) && !aborted_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out   = out_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign abort = abort_q;
    assign err   = err_q;

endmodule

// File: tb/tb_sel_decoder.sv
// Directed scoreboard bench for sel_decoder: default instance plus a NUM_OUT=10 instance.
module tb_sel_decoder;
    import sel_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_sel = 4'd0;
    logic        rdy_m, busy_m, done_m, abort_m, err_m;
    logic [15:0] out_m;
    logic        in_valid2 = 1'b0;
    logic [3:0]  in_sel2 = 4'd0;
    logic        rdy_t, busy_t, done_t, abort_t, err_t;
    logic [9:0]  out_t;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } ent_t;
    ent_t q_m[$];
    ent_t q_t[$];

    always #5 clk = ~clk;

    sel_decoder u_dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(rdy_m), .out(out_m), .busy(busy_m), .done(done_m), .abort(abort_m), .err(err_m)
    );

    sel_decoder #(.NUM_OUT(10)) u_d10 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid2), .in_sel(in_sel2),
        .in_ready(rdy_t), .out(out_t), .busy(busy_t), .done(done_t), .abort(abort_t), .err(err_t)
    );

    // flags = {busy, done, abort, err, in_ready}
    function automatic logic [31:0] pk(input logic [15:0] o, input logic [4:0] f);
        return {11'b0, o, f};
    endfunction

    function automatic logic [31:0] obs_m();
        return pk(out_m, {busy_m, done_m, abort_m, err_m, rdy_m});
    endfunction

    function automatic logic [31:0] obs_t();
        return pk({6'b0, out_t}, {busy_t, done_t, abort_t, err_t, rdy_t});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_m(input string tag, input logic [31:0] e, input int n);
        ent_t x;
        x.tag = tag;
        x.exp = e;
        for (int i = 0; i < n; i++) q_m.push_back(x);
    endtask

    task automatic push_t(input string tag, input logic [31:0] e, input int n);
        ent_t x;
        x.tag = tag;
        x.exp = e;
        for (int i = 0; i < n; i++) q_t.push_back(x);
    endtask

    task automatic step(input int n);
        ent_t x;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (q_m.size() > 0) begin
                x = q_m.pop_front();
                chk(x.tag, obs_m(), x.exp);
            end
            if (q_t.size() > 0) begin
                x = q_t.pop_front();
                chk(x.tag, obs_t(), x.exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            total += 4;
            assert ($onehot0(out_m)) else begin
                bad++;
                $error("FAIL onehot_m: observed %h expected one-hot or zero", out_m);
            end
            assert (out_m == '0 || u_dut.state_q == S_DRIVE) else begin
                bad++;
                $error("FAIL drive_only_m: observed out %h state %0d expected DRIVE", out_m, u_dut.state_q);
            end
            assert ($onehot0(out_t)) else begin
                bad++;
                $error("FAIL onehot_t: observed %h expected one-hot or zero", out_t);
            end
            assert (out_t == '0 || u_d10.state_q == S_DRIVE) else begin
                bad++;
                $error("FAIL drive_only_t: observed out %h state %0d expected DRIVE", out_t, u_d10.state_q);
            end
        end
    end

    initial begin
        #1;
        chk("reset_m", obs_m(), pk(16'h0, 5'b00001));
        chk("reset_t", obs_t(), pk(16'h0, 5'b00001));
        #12 reset = 1'b0;
        @(negedge clk);

        // Single selection, full sequence
        push_m("t1_drive", pk(16'h0020, 5'b10000), 8);
        push_m("t1_hold",  pk(16'h0000, 5'b10000), 3);
        push_m("t1_done",  pk(16'h0000, 5'b11000), 1);
        push_m("t1_ready", pk(16'h0000, 5'b00001), 1);
        in_valid = 1'b1; in_sel = 4'd5;
        step(1);
        in_valid = 1'b0;
        step(12);

        // Held valid with changing code: second accepted only after done
        push_m("t2_drive3", pk(16'h0008, 5'b10000), 8);
        push_m("t2_hold",   pk(16'h0000, 5'b10000), 3);
        push_m("t2_done",   pk(16'h0000, 5'b11000), 1);
        push_m("t2_ready",  pk(16'h0000, 5'b00001), 1);
        push_m("t2_drive9", pk(16'h0200, 5'b10000), 8);
        push_m("t2_hold9",  pk(16'h0000, 5'b10000), 3);
        push_m("t2_done9",  pk(16'h0000, 5'b11000), 1);
        push_m("t2_idle9",  pk(16'h0000, 5'b00001), 1);
        in_valid = 1'b1; in_sel = 4'd3;
        step(1);
        in_sel = 4'd9;
        step(12);
        step(1);
        in_valid = 1'b0;
        step(12);

        // Abort in DRIVE, idle stays blocked while enable low
        push_m("t3_drive",  pk(16'h0004, 5'b10000), 3);
        push_m("t3_abort",  pk(16'h0000, 5'b10100), 1);
        push_m("t3_hold",   pk(16'h0000, 5'b10000), 3);
        push_m("t3_idle",   pk(16'h0000, 5'b00000), 1);
        push_m("t3_blocked", pk(16'h0000, 5'b00000), 1);
        push_m("t3_resume", pk(16'h0002, 5'b10000), 1);
        in_valid = 1'b1; in_sel = 4'd2;
        step(1);
        in_valid = 1'b0;
        step(2);
        enable = 1'b0;
        step(5);
        in_valid = 1'b1; in_sel = 4'd1;
        step(1);
        enable = 1'b1;
        step(1);

        // Asynchronous reset mid-DRIVE, then immediate re-acceptance
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk("rst_async", obs_m(), pk(16'h0, 5'b00001));
        #1 reset = 1'b0;
        in_sel = 4'd0; in_valid = 1'b1;
        push_m("t5_drive", pk(16'h0001, 5'b10000), 8);
        push_m("t5_hold",  pk(16'h0000, 5'b10000), 3);
        push_m("t5_done",  pk(16'h0000, 5'b11000), 1);
        push_m("t5_idle",  pk(16'h0000, 5'b00001), 1);
        step(1);
        in_valid = 1'b0;
        step(12);

        // Out-of-range code on the NUM_OUT=10 instance
`ifdef SEL_DECODER_RANGE_CHECK_EN
        push_t("t4_err",  pk(16'h0, 5'b00011), 1);
        push_t("t4_idle", pk(16'h0, 5'b00001), 1);
        in_valid2 = 1'b1; in_sel2 = 4'd12;
        step(1);
        in_valid2 = 1'b0;
        step(1);
`else
        push_t("t4_drive0", pk(16'h0, 5'b10000), 8);
        push_t("t4_hold",   pk(16'h0, 5'b10000), 3);
        push_t("t4_done",   pk(16'h0, 5'b11000), 1);
        push_t("t4_idle",   pk(16'h0, 5'b00001), 1);
        in_valid2 = 1'b1; in_sel2 = 4'd12;
        step(1);
        in_valid2 = 1'b0;
        step(12);
`endif

        // Highest legal code on the NUM_OUT=10 instance
        push_t("t6_drive", pk(16'h0200, 5'b10000), 8);
        push_t("t6_hold",  pk(16'h0000, 5'b10000), 3);
        push_t("t6_done",  pk(16'h0000, 5'b11000), 1);
        push_t("t6_idle",  pk(16'h0000, 5'b00001), 1);
        in_valid2 = 1'b1; in_sel2 = 4'd9;
        step(1);
        in_valid2 = 1'b0;
        step(12);

        chk("sb_empty", 32'(q_m.size() + q_t.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
